uart_rx_deframer: RTL and testbench

UART_RX_DEFRAMER -- requirements
Module: uart_rx_deframer

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_majority3.sv | 44 ++++
 rtl/uart_rx_deframer.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default oversample ratio and a 2-of-3 vote.
// The PARITY encoding exists only when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int RX_OVERSAMPLE_DEF = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_majority3.sv
// Two-flop synchronizer for the serial line plus a 3-sample majority voter.
// The third sample is the live synchronized line, so the vote is ready on the third sample tick.
module uart_rx_majority3
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_Rx_Data,
  input  logic i_Samp0_En,
  input  logic i_Samp1_En,
  output logic o_Rx_Line,
  output logic o_Vote
);

  logic r_sync1;
  logic r_sync2;
  logic r_samp0;
  logic r_samp1;

  // Idle-high reset keeps the FSM from seeing a false start edge after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_Rx_Data;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_samp0 <= 1'b1;
      r_samp1 <= 1'b1;
    end else begin
      if (i_Samp0_En) r_samp0 <= r_sync2;
      if (i_Samp1_En) r_samp1 <= r_sync2;
    end
  end

  assign o_Rx_Line = r_sync2;
  assign o_Vote    = maj3(r_samp0, r_samp1, r_sync2);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start/data/stop recovery with majority voting.
// Optional parity bit enabled by macro UART_PARITY_EN (adds o_Rx_Parity_Err).
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int RX_OVERSAMPLE = RX_OVERSAMPLE_DEF,
  parameter int PARITY_ODD    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_Rx_Tick,
  input  logic       i_Rx_Data,
  output logic       o_Rx_Done,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Framing_Err,
  output logic       o_Rx_Busy
`ifdef UART_PARITY_EN
  ,
  output logic       o_Rx_Parity_Err
`endif
);

  if ((RX_OVERSAMPLE % 2) != 0 || RX_OVERSAMPLE < 8 || RX_OVERSAMPLE > 64 ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_rx_deframer: illegal RX_OVERSAMPLE or PARITY_ODD");
  end

  localparam logic [5:0] C_LAST = 6'(RX_OVERSAMPLE - 1);
  localparam logic [5:0] C_S0   = 6'(RX_OVERSAMPLE / 2 - 1);
  localparam logic [5:0] C_S1   = 6'(RX_OVERSAMPLE / 2);
  localparam logic [5:0] C_S2   = 6'(RX_OVERSAMPLE / 2 + 1);

  logic [2:0] r_state;
  logic [5:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_done;
  logic [7:0] r_byte;
  logic       r_framing_err;

  logic       w_line;
  logic       w_vote;
  logic       w_samp0_en;
  logic       w_samp1_en;
  logic       w_tick_last;
  logic       w_decide;
  logic [5:0] w_tick_next;

  assign w_samp0_en  = i_Rx_Tick && (r_tick_cnt == C_S0);
  assign w_samp1_en  = i_Rx_Tick && (r_tick_cnt == C_S1);
  assign w_tick_last = (r_tick_cnt == C_LAST);
  assign w_decide    = (r_tick_cnt == C_S2);
  assign w_tick_next = w_tick_last ? 6'd0 : r_tick_cnt + 6'd1;

  uart_rx_majority3 u_majority3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_Rx_Data  (i_Rx_Data),
    .i_Samp0_En (w_samp0_en),
    .i_Samp1_En (w_samp1_en),
    .o_Rx_Line  (w_line),
    .o_Vote     (w_vote)
  );

`ifdef UART_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_tick_cnt    <= 6'd0;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_done        <= 1'b0;
      r_byte        <= 8'h00;
      r_framing_err <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_bit     <= 1'b0;
      r_parity_err  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_Rx_Tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_line) begin
              r_state    <= ST_START;
              r_tick_cnt <= 6'd0;
            end
          end
          ST_START: begin
            r_tick_cnt <= w_tick_next;
            // A start bit that votes high was a glitch; drop back and rearm.
            if (w_decide && w_vote) begin
              r_state    <= ST_IDLE;
              r_tick_cnt <= 6'd0;
            end else if (w_tick_last) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            r_tick_cnt <= w_tick_next;
            if (w_decide) r_shift <= {w_vote, r_shift[7:1]};
            if (w_tick_last) begin
              if (r_bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
`ifdef UART_PARITY_EN
          ST_PARITY: begin
            r_tick_cnt <= w_tick_next;
            if (w_decide) r_par_bit <= w_vote;
            if (w_tick_last) r_state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            r_tick_cnt <= w_tick_next;
            // Decide mid-bit so the rest of the stop bit is spent in IDLE watching for the next start.
            if (w_decide) begin
              r_done        <= 1'b1;
              r_byte        <= r_shift;
              r_framing_err <= ~w_vote;
`ifdef UART_PARITY_EN
              r_parity_err  <= (^r_shift) ^ r_par_bit ^ 1'(PARITY_ODD);
`endif
              r_tick_cnt    <= 6'd0;
              r_state       <= w_vote ? ST_IDLE : ST_WAIT_HIGH;
            end
          end
          ST_WAIT_HIGH: begin
            if (w_line) r_state <= ST_IDLE;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= 6'd0;
          end
        endcase
      end
    end
  end

  assign o_Rx_Done        = r_done;
  assign o_Rx_Byte        = r_byte;
  assign o_Rx_Framing_Err = r_framing_err;
  assign o_Rx_Busy        = (r_state != ST_IDLE);
`ifdef UART_PARITY_EN
  assign o_Rx_Parity_Err  = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at RX_OVERSAMPLE=16, one tick every 4 clks.
// Parity scenarios are built only when UART_PARITY_EN is defined (PARITY_ODD=0).
module tb_uart_rx_deframer;

  logic       clk;
  logic       reset_n;
  logic       i_Rx_Tick;
  logic       i_Rx_Data;
  logic       o_Rx_Done;
  logic [7:0] o_Rx_Byte;
  logic       o_Rx_Framing_Err;
  logic       o_Rx_Busy;
`ifdef UART_PARITY_EN
  logic       o_Rx_Parity_Err;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int run_len  = 0;
  int max_run  = 0;
  logic [7:0] got_q[$];
  logic [1:0] tick_div = 2'd0;

  uart_rx_deframer #(
    .RX_OVERSAMPLE (16),
    .PARITY_ODD    (0)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_Rx_Tick        (i_Rx_Tick),
    .i_Rx_Data        (i_Rx_Data),
    .o_Rx_Done        (o_Rx_Done),
    .o_Rx_Byte        (o_Rx_Byte),
    .o_Rx_Framing_Err (o_Rx_Framing_Err),
    .o_Rx_Busy        (o_Rx_Busy)
`ifdef UART_PARITY_EN
    ,
    .o_Rx_Parity_Err  (o_Rx_Parity_Err)
`endif
  );

  // clock / reset / tick
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    i_Rx_Tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div  = tick_div + 2'd1;
      i_Rx_Tick = (tick_div == 2'd0);
    end
  end

  // done monitor: counts pulses, pulse width and captured bytes
  initial begin
    forever begin
      @(negedge clk);
      if (o_Rx_Done) begin
        done_cnt = done_cnt + 1;
        got_q.push_back(o_Rx_Byte);
        run_len = run_len + 1;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!i_Rx_Tick) @(posedge clk);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    i_Rx_Data = v;
    wait_ticks(n);
  endtask

  // glitch_bit selects a data bit (0..7) inverted for one tick at tick 8; -1 for none.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int glitch_bit, input int stop_ticks);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive_bit(data[i], 8);
        drive_bit(~data[i], 1);
        drive_bit(data[i], 7);
      end else begin
        drive_bit(data[i], 16);
      end
    end
`ifdef UART_PARITY_EN
    drive_bit(par, 16);
`else
    if (par === 1'bx) $display("note: parity argument unused");
`endif
    drive_bit(stop, stop_ticks);
  endtask

  task automatic sample_point();
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    reset_n   = 1'b0;
    i_Rx_Data = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (o_Rx_Done !== 1'b0) $display("FAIL rst_done: got %b expected 0", o_Rx_Done); else n_pass++;
    n_checks++; if (o_Rx_Byte !== 8'h00) $display("FAIL rst_byte: got %h expected 00", o_Rx_Byte); else n_pass++;
    n_checks++; if (o_Rx_Framing_Err !== 1'b0) $display("FAIL rst_ferr: got %b expected 0", o_Rx_Framing_Err); else n_pass++;
    n_checks++; if (o_Rx_Busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", o_Rx_Busy); else n_pass++;
`ifdef UART_PARITY_EN
    n_checks++; if (o_Rx_Parity_Err !== 1'b0) $display("FAIL rst_perr: got %b expected 0", o_Rx_Parity_Err); else n_pass++;
`endif
    reset_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_good_frame();
    int d0;
    d0 = done_cnt;
    max_run = 0;
    send_frame(8'hA5, ^8'hA5, 1'b1, -1, 16);
    sample_point();
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL a5_done_cnt: got %0d expected %0d", done_cnt, d0 + 1); else n_pass++;
    n_checks++; if (o_Rx_Byte !== 8'hA5) $display("FAIL a5_byte: got %h expected a5", o_Rx_Byte); else n_pass++;
    n_checks++; if (o_Rx_Framing_Err !== 1'b0) $display("FAIL a5_ferr: got %b expected 0", o_Rx_Framing_Err); else n_pass++;
    n_checks++; if (max_run !== 1) $display("FAIL a5_pulse_width: got %0d expected 1", max_run); else n_pass++;
    n_checks++; if (o_Rx_Busy !== 1'b0) $display("FAIL a5_busy_idle: got %b expected 0", o_Rx_Busy); else n_pass++;
    wait_ticks(20);
    sample_point();
    n_checks++; if (o_Rx_Byte !== 8'hA5) $display("FAIL a5_byte_hold: got %h expected a5", o_Rx_Byte); else n_pass++;
  endtask

  task automatic test_start_glitch();
    int d0;
    d0 = done_cnt;
    drive_bit(1'b0, 4);
    sample_point();
    n_checks++; if (o_Rx_Busy !== 1'b1) $display("FAIL glitch_busy_start: got %b expected 1", o_Rx_Busy); else n_pass++;
    drive_bit(1'b1, 16);
    sample_point();
    n_checks++; if (o_Rx_Busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", o_Rx_Busy); else n_pass++;
    n_checks++; if (done_cnt !== d0) $display("FAIL glitch_no_done: got %0d expected %0d", done_cnt, d0); else n_pass++;
  endtask

  task automatic test_data_glitch();
    int d0;
    d0 = done_cnt;
    send_frame(8'h3C, ^8'h3C, 1'b1, 2, 16);
    sample_point();
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL 3c_done_cnt: got %0d expected %0d", done_cnt, d0 + 1); else n_pass++;
    n_checks++; if (o_Rx_Byte !== 8'h3C) $display("FAIL 3c_byte: got %h expected 3c", o_Rx_Byte); else n_pass++;
  endtask

  task automatic test_break();
    int d0;
    d0 = done_cnt;
    send_frame(8'h81, ^8'h81, 1'b0, -1, 40);
    sample_point();
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL brk_done_cnt: got %0d expected %0d", done_cnt, d0 + 1); else n_pass++;
    n_checks++; if (o_Rx_Byte !== 8'h81) $display("FAIL brk_byte: got %h expected 81", o_Rx_Byte); else n_pass++;
    n_checks++; if (o_Rx_Framing_Err !== 1'b1) $display("FAIL brk_ferr: got %b expected 1", o_Rx_Framing_Err); else n_pass++;
    n_checks++; if (o_Rx_Busy !== 1'b1) $display("FAIL brk_busy_low: got %b expected 1", o_Rx_Busy); else n_pass++;
    drive_bit(1'b1, 4);
    sample_point();
    n_checks++; if (o_Rx_Busy !== 1'b0) $display("FAIL brk_busy_high: got %b expected 0", o_Rx_Busy); else n_pass++;
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL brk_no_extra_done: got %0d expected %0d", done_cnt, d0 + 1); else n_pass++;
    send_frame(8'h55, ^8'h55, 1'b1, -1, 16);
    sample_point();
    n_checks++; if (o_Rx_Byte !== 8'h55) $display("FAIL brk_next_byte: got %h expected 55", o_Rx_Byte); else n_pass++;
    n_checks++; if (o_Rx_Framing_Err !== 1'b0) $display("FAIL brk_next_ferr: got %b expected 0", o_Rx_Framing_Err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    send_frame(8'h00, ^8'h00, 1'b1, -1, 16);
    send_frame(8'hFF, ^8'hFF, 1'b1, -1, 16);
    sample_point();
    n_checks++; if (done_cnt !== d0 + 2) $display("FAIL b2b_done_cnt: got %0d expected %0d", done_cnt, d0 + 2); else n_pass++;
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[got_q.size() - 2] !== 8'h00) $display("FAIL b2b_byte0: got %h expected 00", got_q[got_q.size() - 2]); else n_pass++;
      n_checks++; if (got_q[got_q.size() - 1] !== 8'hFF) $display("FAIL b2b_byte1: got %h expected ff", got_q[got_q.size() - 1]); else n_pass++;
    end else begin
      n_checks++;
      $display("FAIL b2b_capture: got %0d bytes expected at least 2", got_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0;
    d0 = done_cnt;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    sample_point();
    n_checks++; if (o_Rx_Busy !== 1'b1) $display("FAIL mid_busy_before: got %b expected 1", o_Rx_Busy); else n_pass++;
    reset_n = 1'b0;
    #2;
    n_checks++; if (o_Rx_Byte !== 8'h00) $display("FAIL mid_rst_byte: got %h expected 00", o_Rx_Byte); else n_pass++;
    n_checks++; if (o_Rx_Busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", o_Rx_Busy); else n_pass++;
    n_checks++; if (o_Rx_Done !== 1'b0 || o_Rx_Framing_Err !== 1'b0) $display("FAIL mid_rst_flags: got %b%b expected 00", o_Rx_Done, o_Rx_Framing_Err); else n_pass++;
    i_Rx_Data = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(40);
    sample_point();
    n_checks++; if (done_cnt !== d0) $display("FAIL mid_no_done: got %0d expected %0d", done_cnt, d0); else n_pass++;
    send_frame(8'h5A, ^8'h5A, 1'b1, -1, 16);
    sample_point();
    n_checks++; if (o_Rx_Byte !== 8'h5A) $display("FAIL mid_next_byte: got %h expected 5a", o_Rx_Byte); else n_pass++;
    n_checks++; if (done_cnt !== d0 + 1) $display("FAIL mid_next_done: got %0d expected %0d", done_cnt, d0 + 1); else n_pass++;
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b0, 1'b1, -1, 16);
    sample_point();
    n_checks++; if (o_Rx_Parity_Err !== 1'b1) $display("FAIL par_bad: got %b expected 1", o_Rx_Parity_Err); else n_pass++;
    n_checks++; if (o_Rx_Byte !== 8'h01) $display("FAIL par_bad_byte: got %h expected 01", o_Rx_Byte); else n_pass++;
    send_frame(8'h01, 1'b1, 1'b1, -1, 16);
    sample_point();
    n_checks++; if (o_Rx_Parity_Err !== 1'b0) $display("FAIL par_good: got %b expected 0", o_Rx_Parity_Err); else n_pass++;
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    i_Rx_Data = 1'b1;
    test_reset();
    test_good_frame();
    test_start_glitch();
    test_data_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
